vote_tally: RTL and testbench

Sequential ballot collector. It is the consuming end of a serial ballot stream: voters present ballots one at a time over a valid/ready handshake, and the block counts them and registers a majority verdict once a session is complete. It scales the three-input majority function to N voters arriving over time. It sits between a ballot source (switch debouncer or upstream FSM) and whatever consumes the verdict.

---
 rtl/vote_tally_if.sv | 24 ++
 rtl/vote_tally.sv | 80 ++++++++
 tb/tb_vote_tally.sv | 133 +++++++++++++
 3 files changed

// File: rtl/vote_tally_if.sv
// rtl/vote_tally_if.sv - ballot stream and verdict bundle between a ballot source and vote_tally
interface vote_tally_if #(
    parameter int CW = 2
);
    logic          start;
    logic          ballot_valid;
    logic          ballot;
    logic          ballot_ready;
    logic          busy;
    logic          done;
    logic          Y;
    logic [CW-1:0] yes_count;
    logic [CW-1:0] total_count;

    modport master (
        output start, ballot_valid, ballot,
        input  ballot_ready, busy, done, Y, yes_count, total_count
    );

    modport slave (
        input  start, ballot_valid, ballot,
        output ballot_ready, busy, done, Y, yes_count, total_count
    );
endinterface

// File: rtl/vote_tally.sv
// rtl/vote_tally.sv - sequential N-voter ballot collector with registered majority verdict
module vote_tally #(
    parameter int N_VOTERS = 3,
    parameter int CW       = 2
) (
    input  logic         clk,
    input  logic         reset,
    vote_tally_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    localparam logic [CW:0] N_W = (CW+1)'(N_VOTERS);

    state_t        state_q, state_d;
    logic [CW-1:0] yes_q, yes_d;
    logic [CW-1:0] total_q, total_d;
    logic          y_q, y_d;
    logic          xfer;
    logic [CW:0]   yes_next;
    logic [CW:0]   total_next;

    always_comb begin
        state_d    = state_q;
        yes_d      = yes_q;
        total_d    = total_q;
        y_d        = y_q;
        xfer       = (state_q == COLLECT) && bus.ballot_valid;
        // One bit wider than the counters so the final compare cannot wrap.
        yes_next   = {1'b0, yes_q} + {{CW{1'b0}}, bus.ballot};
        total_next = {1'b0, total_q} + (CW+1)'(1);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = COLLECT;
                    yes_d   = '0;
                    total_d = '0;
                    y_d     = 1'b0;
                end
            end
            COLLECT: begin
                if (xfer) begin
                    yes_d   = yes_next[CW-1:0];
                    total_d = total_next[CW-1:0];
                    if (total_next == N_W) begin
                        state_d = DONE;
                        y_d     = ({yes_next[CW-1:0], 1'b0} > N_W);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            yes_q   <= '0;
            total_q <= '0;
            y_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            yes_q   <= yes_d;
            total_q <= total_d;
            y_q     <= y_d;
        end
    end

    assign bus.ballot_ready = (state_q == COLLECT);
    assign bus.busy         = (state_q == COLLECT);
    assign bus.done         = (state_q == DONE);
    assign bus.Y            = y_q;
    assign bus.yes_count    = yes_q;
    assign bus.total_count  = total_q;
endmodule

// File: tb/tb_vote_tally.sv
// tb/tb_vote_tally.sv - directed table-driven bench for vote_tally (N=3, N=4 and N=1 instances)
module tb_vote_tally;
    logic clk;
    logic reset;

    vote_tally_if #(.CW(2)) if3 ();
    vote_tally_if #(.CW(3)) if4 ();
    vote_tally_if #(.CW(1)) if1 ();

    vote_tally #(.N_VOTERS(3), .CW(2)) dut3 (.clk(clk), .reset(reset), .bus(if3.slave));
    vote_tally #(.N_VOTERS(4), .CW(3)) dut4 (.clk(clk), .reset(reset), .bus(if4.slave));
    vote_tally #(.N_VOTERS(1), .CW(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // Row: inputs driven this cycle; exp = outputs observed before the edge,
    // packed as {ready, busy, done, Y, yes[1:0], total[1:0]}.
    typedef struct {
        logic       rst;
        logic       st;
        logic       v;
        logic       b;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic st, input logic v, input logic b,
                       input logic [7:0] exp);
        vec_t r;
        r.rst = rst; r.st = st; r.v = v; r.b = b; r.exp = exp;
        tbl.push_back(r);
    endtask

    task automatic run4(input logic [3:0] bits, input logic exp_y, input logic [2:0] exp_yes);
        @(negedge clk);
        if4.start = 1'b1;
        @(negedge clk);
        if4.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("n4_ready%0d", i), 32'(if4.ballot_ready), 32'd1);
            if4.ballot_valid = 1'b1;
            if4.ballot       = bits[i];
            @(negedge clk);
        end
        if4.ballot_valid = 1'b0;
        check("n4_done", 32'(if4.done), 32'd1);
        check("n4_y", 32'(if4.Y), 32'(exp_y));
        check("n4_yes", 32'(if4.yes_count), 32'(exp_yes));
        check("n4_total", 32'(if4.total_count), 32'd4);
        @(negedge clk);
        check("n4_done_pulse", 32'(if4.done), 32'd0);
        check("n4_y_hold", 32'(if4.Y), 32'(exp_y));
    endtask

    task automatic run1(input logic b);
        @(negedge clk);
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        check("n1_ready", 32'(if1.ballot_ready), 32'd1);
        if1.ballot_valid = 1'b1;
        if1.ballot       = b;
        @(negedge clk);
        if1.ballot_valid = 1'b0;
        check("n1_done", 32'(if1.done), 32'd1);
        check("n1_y", 32'(if1.Y), 32'(b));
        check("n1_total", 32'(if1.total_count), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        {if3.start, if3.ballot_valid, if3.ballot} = 3'b000;
        {if4.start, if4.ballot_valid, if4.ballot} = 3'b000;
        {if1.start, if1.ballot_valid, if1.ballot} = 3'b000;

        // 1,1,0 back to back
        add(0,1,0,0,8'b0000_0000); add(0,0,1,1,8'b1100_0000); add(0,0,1,1,8'b1100_0101);
        add(0,0,1,0,8'b1100_1010); add(0,0,0,0,8'b0011_1011); add(0,0,0,0,8'b0001_1011);
        // 0,1,0 with two-cycle gaps; ballot held high during gaps
        add(0,1,0,0,8'b0001_1011); add(0,0,1,0,8'b1100_0000); add(0,0,0,1,8'b1100_0001);
        add(0,0,0,1,8'b1100_0001); add(0,0,1,1,8'b1100_0001); add(0,0,0,0,8'b1100_0110);
        add(0,0,0,0,8'b1100_0110); add(0,0,1,0,8'b1100_0110); add(0,0,0,0,8'b0010_0111);
        // five ignored ballots in IDLE, then 0,0,0
        for (int i = 0; i < 5; i++) add(0,0,1,1,8'b0000_0111);
        add(0,1,0,0,8'b0000_0111); add(0,0,1,0,8'b1100_0000); add(0,0,1,0,8'b1100_0001);
        add(0,0,1,0,8'b1100_0010); add(0,0,0,0,8'b0010_0011);
        // reset after two yes ballots, then 0,0,1
        add(0,1,0,0,8'b0000_0011); add(0,0,1,1,8'b1100_0000); add(0,0,1,1,8'b1100_0101);
        add(1,0,1,0,8'b1100_1010); add(0,1,0,0,8'b0000_0000); add(0,0,1,0,8'b1100_0000);
        add(0,0,1,0,8'b1100_0001); add(0,0,1,1,8'b1100_0010); add(0,0,0,0,8'b0010_0111);
        // start held high through 1,1,1 and DONE
        add(0,1,0,0,8'b0000_0111); add(0,1,1,1,8'b1100_0000); add(0,1,1,1,8'b1100_0101);
        add(0,1,1,1,8'b1100_1010); add(0,1,0,0,8'b0011_1111); add(0,1,0,0,8'b0001_1111);
        add(0,0,0,0,8'b1100_0000); add(1,0,0,0,8'b1100_0000); add(0,0,0,0,8'b0000_0000);

        repeat (2) @(negedge clk);
        check("rst_n4", {if4.ballot_ready, if4.busy, if4.done, if4.Y, if4.yes_count, if4.total_count}, 32'd0);
        check("rst_n1", {if1.ballot_ready, if1.busy, if1.done, if1.Y, if1.yes_count, if1.total_count}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            check($sformatf("row%0d", i),
                  32'({if3.ballot_ready, if3.busy, if3.done, if3.Y, if3.yes_count, if3.total_count}),
                  32'(tbl[i].exp));
            reset            = tbl[i].rst;
            if3.start        = tbl[i].st;
            if3.ballot_valid = tbl[i].v;
            if3.ballot       = tbl[i].b;
        end

        run4(4'b0101, 1'b0, 3'd2);
        run4(4'b0111, 1'b1, 3'd3);
        run1(1'b1);
        run1(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
